uart_dump_tx: RTL and testbench

- Host-readback path: the opposite end of the UART program loader, which receives words from the host and writes them into program ROM / dmemory32.
- Reads a block of 32-bit words from a synchronous memory port and transmits them to the host over the tx line.
- Format: 8N1, each word sent as four bytes, least-significant byte first.
- Sits beside the uart loader in top, sharing tx through an external mux, so memory contents can be verified after a CPU run.

---
 rtl/uart_dump_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_dump_tx.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dump_tx.sv
// rtl/uart_dump_tx.sv - reads a block of 32-bit words from memory and sends them LSB byte first as 8N1 on tx
//
// Ports:
//   clk        system clock, single domain
//   rst        synchronous active-low reset
//   start      one-cycle dump request, ignored while busy
//   base_adr   first word address, sampled when start is accepted
//   word_cnt   number of words to send (0 .. 2^ADR_W), sampled when start is accepted
//   mem_re_o   memory read strobe, high only in FETCH
//   mem_adr_o  memory word address, held outside FETCH
//   mem_dat_i  memory read data, valid one cycle after mem_re_o
//   busy       high in every state except IDLE
//   done       one-cycle pulse when a dump finishes
//   tx         serial line, idle high

module uart_dump_tx #(
    parameter int CLK_HZ = 10000000,
    parameter int BAUD   = 115200,
    parameter int ADR_W  = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] base_adr,
    input  logic [ADR_W:0]   word_cnt,
    output logic             mem_re_o,
    output logic [ADR_W-1:0] mem_adr_o,
    input  logic [31:0]      mem_dat_i,
    output logic             busy,
    output logic             done,
    output logic             tx
);

    // Whole clock cycles per bit; rounding to nearest, no fractional carry.
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_START,
        S_DATA,
        S_STOP,
        S_FIN
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [ADR_W-1:0] cur_adr;
    logic [ADR_W-1:0] adr_q;
    logic [ADR_W:0]   remaining;
    logic [31:0]      word_q;
    logic [1:0]       byte_idx;
    logic [2:0]       bit_idx;
    logic [CW-1:0]    baud_cnt;
    logic             in_bit;
    logic             bit_end;

    assign in_bit    = (state == S_START) || (state == S_DATA) || (state == S_STOP);
    assign bit_end   = in_bit && (baud_cnt == DIV_M1);
    assign mem_adr_o = adr_q;

    // State register plus datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            cur_adr   <= '0;
            adr_q     <= '0;
            remaining <= '0;
            word_q    <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else begin
            state <= state_n;
            // Counter restarts at every bit boundary and is parked outside the bit states,
            // so each state entry starts a fresh DIV-cycle bit.
            if (in_bit && !bit_end) begin
                baud_cnt <= baud_cnt + CW'(1);
            end else begin
                baud_cnt <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur_adr   <= base_adr;
                        remaining <= word_cnt;
                        if (word_cnt != '0) begin
                            adr_q <= base_adr;
                        end
                    end
                end
                S_WAIT: begin
                    word_q   <= mem_dat_i;
                    byte_idx <= '0;
                    bit_idx  <= '0;
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else begin
                            remaining <= remaining - (ADR_W + 1)'(1);
                            cur_adr   <= cur_adr + ADR_W'(1);
                            // Only move the visible address when another fetch follows.
                            if (remaining != (ADR_W + 1)'(1)) begin
                                adr_q <= cur_adr + ADR_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (word_cnt == '0) ? S_FIN : S_FETCH;
                end
            end
            S_FETCH: state_n = S_WAIT;
            S_WAIT:  state_n = S_START;
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end && (bit_idx == 3'd7)) begin
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (byte_idx != 2'd3) begin
                        state_n = S_START;
                    end else if (remaining == (ADR_W + 1)'(1)) begin
                        state_n = S_FIN;
                    end else begin
                        state_n = S_FETCH;
                    end
                end
            end
            S_FIN:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        tx       = 1'b1;
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        mem_re_o = (state == S_FETCH);
        case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = word_q[{byte_idx, bit_idx}];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_dump_tx.sv
// tb/tb_uart_dump_tx.sv - scoreboard bench for uart_dump_tx

module tb_uart_dump_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] base_adr;
    logic [14:0] word_cnt;
    logic        mem_re_o;
    logic [13:0] mem_adr_o;
    logic [31:0] mem_dat;
    logic        busy;
    logic        done;
    logic        tx;

    logic        start_b;
    logic        mem_re_b;
    logic [13:0] mem_adr_b;
    logic        busy_b;
    logic        done_b;
    logic        tx_b;

    logic [31:0] mem [0:16383];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    bit          dec_en = 1'b1;
    logic [7:0]  exp_q[$];
    int          fall_q[$];
    logic [13:0] rd_q[$];

    always #5 clk = ~clk;

    uart_dump_tx #(.CLK_HZ(16), .BAUD(1), .ADR_W(14)) dut (
        .clk(clk), .rst(rst), .start(start), .base_adr(base_adr), .word_cnt(word_cnt),
        .mem_re_o(mem_re_o), .mem_adr_o(mem_adr_o), .mem_dat_i(mem_dat),
        .busy(busy), .done(done), .tx(tx)
    );

    uart_dump_tx dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_adr(14'd0), .word_cnt(15'd1),
        .mem_re_o(mem_re_b), .mem_adr_o(mem_adr_b), .mem_dat_i(32'hFFFF_FFFF),
        .busy(busy_b), .done(done_b), .tx(tx_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_re_o) mem_dat <= mem[mem_adr_o];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: reads and done pulses.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (mem_re_o) rd_q.push_back(mem_adr_o);
    end

    // Monitor: UART decoder (DIV=16), compares each byte against the scoreboard.
    initial begin
        logic [7:0] b;
        logic       stopb;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                fall_q.push_back(cyc);
                repeat (8) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx;
                end
                repeat (16) @(negedge clk);
                stopb = tx;
                if (dec_en) begin
                    check("stop_bit", {31'd0, stopb}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte actual=%0h required=none", b);
                    end else begin
                        check("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    task automatic clear_q();
        exp_q.delete();
        fall_q.delete();
        rd_q.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endtask

    // Returns at the negedge right after the accepting edge (cycle k+1).
    task automatic do_start(input logic [13:0] b, input logic [14:0] c, output int k);
        @(negedge clk);
        base_adr = b;
        word_cnt = c;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        base_adr = 14'h1555;
        word_cnt = 15'd7;
        k        = cyc;
    endtask

    task automatic wait_done(input int limit, output int dc);
        dc = -1;
        for (int i = 0; i < limit; i++) begin
            if (done) begin
                dc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (dc < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=pulse");
        end
    endtask

    initial begin
        int k;
        int dc;
        int d0;
        int n;
        rst = 1'b0; start = 1'b0; start_b = 1'b0; base_adr = '0; word_cnt = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_re", mem_re_o, 0);
        check("rst_adr", mem_adr_o, 0);
        check("rst_b_tx", tx_b, 1);
        rst = 1'b1;

        // Single word.
        mem[5] = 32'h1234_5678;
        clear_q(); d0 = done_cnt;
        push_word(32'h1234_5678);
        do_start(14'd5, 15'd1, k);
        check("t1_re", mem_re_o, 1);
        check("t1_adr", mem_adr_o, 5);
        @(negedge clk);
        check("t1_re_wait", mem_re_o, 0);
        check("t1_tx_wait", tx, 1);
        wait_done(800, dc);
        check("t1_done_cyc", dc, k + 642);
        check("t1_busy_fin", busy, 1);
        @(negedge clk);
        check("t1_busy_after", busy, 0);
        check("t1_done_after", done, 0);
        repeat (2) @(negedge clk);
        check("t1_frames", fall_q.size(), 4);
        if (fall_q.size() == 4) begin
            check("t1_first_fall", fall_q[0], k + 2);
            for (int i = 1; i < 4; i++) check("t1_frame_len", fall_q[i] - fall_q[i-1], 160);
        end
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_done_cnt", done_cnt - d0, 1);

        // Two words with address wrap.
        mem[14'h3FFF] = 32'hA5A5_A5A5;
        mem[0]        = 32'h0000_00FF;
        clear_q();
        push_word(32'hA5A5_A5A5);
        push_word(32'h0000_00FF);
        do_start(14'h3FFF, 15'd2, k);
        wait_done(1600, dc);
        check("t2_done_cyc", dc, k + 1284);
        repeat (3) @(negedge clk);
        check("t2_reads", rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            check("t2_rd0", rd_q[0], 14'h3FFF);
            check("t2_rd1", rd_q[1], 0);
        end
        if (fall_q.size() == 8) check("t2_word_gap", fall_q[4] - fall_q[3], 162);
        else check("t2_frames", fall_q.size(), 8);
        check("t2_q_empty", exp_q.size(), 0);

        // Zero count.
        clear_q(); d0 = done_cnt;
        do_start(14'd100, 15'd0, k);
        check("t3_done", done, 1);
        check("t3_busy", busy, 1);
        check("t3_re", mem_re_o, 0);
        check("t3_tx", tx, 1);
        @(negedge clk);
        check("t3_busy_after", busy, 0);
        check("t3_done_after", done, 0);
        repeat (20) @(negedge clk);
        check("t3_no_reads", rd_q.size(), 0);
        check("t3_no_frames", fall_q.size(), 0);
        check("t3_done_cnt", done_cnt - d0, 1);

        // Start while busy is ignored.
        clear_q(); d0 = done_cnt;
        push_word(32'h1234_5678);
        do_start(14'd5, 15'd1, k);
        repeat (40) @(negedge clk);
        base_adr = 14'd0; word_cnt = 15'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(800, dc);
        check("t4_done_cyc", dc, k + 642);
        repeat (300) @(negedge clk);
        check("t4_done_cnt", done_cnt - d0, 1);
        check("t4_reads", rd_q.size(), 1);
        if (rd_q.size() == 1) check("t4_rd0", rd_q[0], 5);
        check("t4_q_empty", exp_q.size(), 0);
        check("t4_idle", busy, 0);

        // Reset mid-frame.
        clear_q(); dec_en = 1'b0; d0 = done_cnt;
        do_start(14'd5, 15'd1, k);
        repeat (49) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_tx", tx, 1);
        check("t5_busy", busy, 0);
        check("t5_re", mem_re_o, 0);
        check("t5_adr", mem_adr_o, 0);
        rst = 1'b1;
        repeat (300) @(negedge clk);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_still_idle", busy, 0);
        clear_q(); dec_en = 1'b1;
        push_word(32'h1234_5678);
        do_start(14'd5, 15'd1, k);
        check("t5_re2", mem_re_o, 1);
        check("t5_adr2", mem_adr_o, 5);
        wait_done(800, dc);
        check("t5_done_cyc", dc, k + 642);
        repeat (2) @(negedge clk);
        if (fall_q.size() > 0) check("t5_first_fall", fall_q[0], k + 2);
        else check("t5_frames", fall_q.size(), 4);
        check("t5_q_empty", exp_q.size(), 0);

        // Default parameters: start bit width.
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        n = 0;
        while (tx_b !== 1'b0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t6_fall_found", {31'd0, tx_b}, 0);
        n = 0;
        while (tx_b === 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t6_start_width", n, 87);
        n = 0;
        while (done_b !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("t6_done", {31'd0, done_b}, 1);
        @(negedge clk);
        check("t6_busy_after", busy_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
